// File: rtl/prefetch_request_arbiter.sv
// -----------------------------------------------------------------------------
// prefetch_request_arbiter
//
// Shares the single prefetch request port of the prefetch buffer's DMA path
// between NUM_REQ independent predictors.
//
// - Round-robin arbitration. The request to the DMA is registered and held
//   stable under valid/ready.
// - A credit count limits the number of prefetches in flight. DMA
//   completions return the credits.
// - A request whose address equals the last issued address is accepted and
//   dropped instead of being issued again.
//
// Ports
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   req_valid_i      per-requester request valid                 [NUM_REQ]
//   req_addr_i       per-requester address, packed k*ADDR_WIDTH  [NUM_REQ*ADDR_WIDTH]
//   req_size_i       per-requester size, same packing            [NUM_REQ*ADDR_WIDTH]
//   req_ready_o      one-hot accept pulse to the winning requester
//   dma_req_valid_o  request valid towards the DMA
//   dma_req_addr_o   request address
//   dma_req_size_o   request size
//   dma_req_id_o     index of the requester that owns the request
//   dma_req_ready_i  DMA accepts the request
//   cpl_valid_i      one prefetch completed (one pulse per request)
//   flush_i          stop granting, clear the duplicate filter
//   credits_o        available credits
//   issued_cnt_o     requests issued to the DMA (wraps)
//   dropped_cnt_o    duplicate requests suppressed (wraps)
//   busy_o           request pending or prefetches still in flight
// -----------------------------------------------------------------------------
module prefetch_request_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ID_WIDTH        = $clog2(NUM_REQ),
    parameter int CREDIT_WIDTH    = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_size_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          dma_req_valid_o,
    output logic [ADDR_WIDTH-1:0]         dma_req_addr_o,
    output logic [ADDR_WIDTH-1:0]         dma_req_size_o,
    output logic [ID_WIDTH-1:0]           dma_req_id_o,
    input  logic                          dma_req_ready_i,
    input  logic                          cpl_valid_i,
    input  logic                          flush_i,
    output logic [CREDIT_WIDTH-1:0]       credits_o,
    output logic [15:0]                   issued_cnt_o,
    output logic [15:0]                   dropped_cnt_o,
    output logic                          busy_o
);

    localparam logic [CREDIT_WIDTH-1:0] CREDITS_FULL = CREDIT_WIDTH'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q;
    logic [CREDIT_WIDTH-1:0] credits_q;
    logic                    last_valid_q;
    logic [ADDR_WIDTH-1:0]   last_addr_q;
    logic [ADDR_WIDTH-1:0]   out_addr_q;
    logic [ADDR_WIDTH-1:0]   out_size_q;
    logic [ID_WIDTH-1:0]     out_id_q;
    logic [15:0]             issued_cnt_q;
    logic [15:0]             dropped_cnt_q;

    // Unpacked views of the flat requester buses.
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [ADDR_WIDTH-1:0] size_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_arr[k] = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign size_arr[k] = req_size_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // (base + off) modulo NUM_REQ. Works for NUM_REQ that is not a power of two.
    function automatic logic [ID_WIDTH-1:0] rr_index(input logic [ID_WIDTH-1:0] base,
                                                     input int unsigned         off);
        int unsigned sum;
        sum = ({{(32-ID_WIDTH){1'b0}}, base} + off) % NUM_REQ;
        return sum[ID_WIDTH-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // Round-robin winner search, starting at rr_ptr
    // -------------------------------------------------------------------------
    logic                win_found;
    logic [ID_WIDTH-1:0] win_idx;
    logic [ID_WIDTH-1:0] cand;

    // NOTE: every signal driven by an always_comb gets a default value first.
    // That way no path leaves a signal unassigned, and no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = rr_index(rr_ptr_q, i);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant only from IDLE, with a credit available and no flush. The reset
    // term keeps req_ready_o at 0 while reset is applied.
    logic grant;
    logic grant_dup;
    logic handshake;

    assign grant     = !rst_i && (state_q == IDLE) && !flush_i &&
                       (credits_q != '0) && win_found;
    assign grant_dup = grant && last_valid_q && (addr_arr[win_idx] == last_addr_q);
    assign handshake = (state_q == ISSUE) && dma_req_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (grant) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant && !grant_dup) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Valid is never withdrawn, even when a flush arrives.
                // Leave ISSUE only on the handshake.
                if (dma_req_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together on the clock edge, whatever order the statements
    // are written in.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Request registers, round-robin pointer, duplicate filter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q     <= '0;
            out_addr_q   <= '0;
            out_size_q   <= '0;
            out_id_q     <= '0;
            last_valid_q <= 1'b0;
            last_addr_q  <= '0;
        end else begin
            if (grant && !grant_dup) begin
                out_addr_q <= addr_arr[win_idx];
                out_size_q <= size_arr[win_idx];
                out_id_q   <= win_idx;
            end

            // A dropped duplicate moves the pointer past its owner straight
            // away. An issued request moves it only on its handshake.
            if (grant_dup) begin
                rr_ptr_q <= rr_index(win_idx, 1);
            end else if (handshake) begin
                rr_ptr_q <= rr_index(out_id_q, 1);
            end

            if (handshake) begin
                last_addr_q <= out_addr_q;
            end

            // Flush clears the filter and takes priority over the handshake
            // that would otherwise arm it.
            if (flush_i) begin
                last_valid_q <= 1'b0;
            end else if (handshake) begin
                last_valid_q <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Credits and statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credits_q     <= CREDITS_FULL;
            issued_cnt_q  <= '0;
            dropped_cnt_q <= '0;
        end else begin
            // A handshake and a completion in the same cycle cancel out.
            // A completion that arrives with credits already full is ignored.
            if (handshake && !cpl_valid_i) begin
                credits_q <= credits_q - 1'b1;
            end else if (!handshake && cpl_valid_i && (credits_q < CREDITS_FULL)) begin
                credits_q <= credits_q + 1'b1;
            end

            if (handshake) begin
                issued_cnt_q <= issued_cnt_q + 16'd1;
            end
            if (grant_dup) begin
                dropped_cnt_q <= dropped_cnt_q + 16'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign dma_req_valid_o = (state_q == ISSUE);
    assign dma_req_addr_o  = out_addr_q;
    assign dma_req_size_o  = out_size_q;
    assign dma_req_id_o    = out_id_q;
    assign credits_o       = credits_q;
    assign issued_cnt_o    = issued_cnt_q;
    assign dropped_cnt_o   = dropped_cnt_q;
    assign busy_o          = (state_q != IDLE) || (credits_q < CREDITS_FULL);

endmodule
